data_file: RTL

// - Data memory of the 8-bit CPU, and the counterpart of the accumulator.
// - Its read port drives the accumulator's file_in for load operations.
// - Its write port takes the accumulator value (ac) on store operations.
// - It also has a self-timed clear sequencer, so the control unit can zero
//   all of data memory without a software loop.

---
 rtl/data_file_pkg.sv | 20 ++
 rtl/data_file_if.sv | 23 ++
 rtl/data_file.sv | 110 +++++++++++
 3 files changed

// File: rtl/data_file_pkg.sv
// Shared definitions for the 8-bit CPU data memory and its co-simulating benches.
package data_file_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    // Sequencer state, one bit: idle/serving the CPU, or sweeping zeros through memory.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    // Accumulator enable codes issued by the control unit.
    typedef enum logic [1:0] {
        AC_HOLD = 2'd0,
        AC_ALU  = 2'd1,
        AC_FILE = 2'd2
    } ac_en_e;

endpackage

// File: rtl/data_file_if.sv
// Control-unit <-> data memory bus: store strobe, address, data in both directions,
// and the clear request/busy pair.
interface data_file_if #(
    parameter int DW = 8,
    parameter int AW = 4
) ();
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          clr;
    logic          busy;

    modport master (
        output we, addr, wdata, clr,
        input  rdata, busy
    );

    modport slave (
        input  we, addr, wdata, clr,
        output rdata, busy
    );
endinterface

// File: rtl/data_file.sv
// Data memory of the 8-bit CPU: combinational read port feeding the accumulator,
// synchronous store port, and a self-timed sequencer that zeroes every entry.
module data_file
    import data_file_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic      clk,
    input  logic      rst,
    data_file_if.slave bus
);

    localparam int             DEPTH    = 2 ** AW;
    localparam logic [AW-1:0]  PTR_LAST = AW'(DEPTH - 1);

    state_e        state_r;
    state_e        state_nxt_s;
    logic [AW-1:0] ptr_r;
    logic          busy_r;
    logic [DW-1:0] mem_r [DEPTH];

    logic          wr_en_s;
    logic          clr_en_s;
    logic [DW-1:0] rdata_s;

    // Sequencer state, clear pointer and registered busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_CLEAR);
            // The pointer only advances while sweeping; it wraps to zero on the
            // exit edge, which leaves it ready for the next sequence.
            if (state_r == S_CLEAR) begin
                ptr_r <= ptr_r + AW'(1);
            end else begin
                ptr_r <= {AW{1'b0}};
            end
        end
    end

    // Next-state: start a sweep on clr from idle; leave after the last entry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.clr) begin
                    state_nxt_s = S_CLEAR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                // clr is deliberately ignored here: the sweep is never restarted.
                if (ptr_r == PTR_LAST) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_CLEAR;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode: write/clear enables and the gated read data.
    always_comb begin
        wr_en_s  = 1'b0;
        clr_en_s = 1'b0;
        rdata_s  = {DW{1'b0}};
        case (state_r)
            S_IDLE: begin
                // A clear request in the same cycle wins over the store.
                wr_en_s = bus.we & ~bus.clr;
            end
            S_CLEAR: begin
                clr_en_s = 1'b1;
            end
            default: begin
                wr_en_s  = 1'b0;
                clr_en_s = 1'b0;
            end
        endcase
        if (busy_r) begin
            rdata_s = {DW{1'b0}};
        end else begin
            rdata_s = mem_r[bus.addr];
        end
    end

    // Storage array: per-entry async reset, sweep zeroing, then CPU stores.
    always_ff @(posedge clk or negedge rst) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst) begin
                mem_r[i] <= {DW{1'b0}};
            end else if (clr_en_s && (ptr_r == AW'(i))) begin
                mem_r[i] <= {DW{1'b0}};
            end else if (wr_en_s && (bus.addr == AW'(i))) begin
                mem_r[i] <= bus.wdata;
            end
        end
    end

    assign bus.rdata = rdata_s;
    assign bus.busy  = busy_r;

endmodule
